// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: in-flight tracker entry, tracker depth and
// tracker slot positions.
package rv_pipe_pkg;

  localparam int unsigned TrackDepth = 3;
  localparam int unsigned TrkEx      = 0;
  localparam int unsigned TrkMem     = 1;
  localparam int unsigned TrkWb      = 2;

  localparam logic [4:0] RegX0 = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
  } trk_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// ID-stage RAW hazard detector: tracks in-flight destination registers in
// EX/MEM/WB and generates stall / flush controls plus performance counters.
module id_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int unsigned WB_BYPASS = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             ID_insn_vld,
  input  logic [4:0]       ID_rs1_addr,
  input  logic [4:0]       ID_rs2_addr,
  input  logic             ID_rs1_used,
  input  logic             ID_rs2_used,
  input  logic [4:0]       ID_rd_addr,
  input  logic             ID_rd_wren,
  input  logic             EX_br_taken,
  output logic             o_pc_stall,
  output logic             o_IF_stall,
  output logic             o_ID_flush,
  output logic             EX_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  trk_entry_t trk_q [TrackDepth];
  trk_entry_t trk_d [TrackDepth];

  logic [TrackDepth-1:0] entry_hit;
  logic                  hazard;
  logic                  issue;
  logic                  stall_inc;

  function automatic logic src_match(input logic       used,
                                     input logic [4:0] addr,
                                     input trk_entry_t e);
    return used && (addr != RegX0) && e.valid && (e.rd == addr);
  endfunction

  always_comb begin
    entry_hit = '0;
    for (int i = 0; i < TrackDepth; i++) begin
      entry_hit[i] = src_match(ID_rs1_used, ID_rs1_addr, trk_q[i]) |
                     src_match(ID_rs2_used, ID_rs2_addr, trk_q[i]);
    end
  end

  // With WB bypass the register file forwards the WB write, so WB is not a hazard.
  assign hazard = ID_insn_vld &
                  (entry_hit[TrkEx] | entry_hit[TrkMem] |
                   ((WB_BYPASS == 0) & entry_hit[TrkWb]));

  assign issue     = ID_insn_vld & ~hazard & ~EX_br_taken;
  assign stall_inc = hazard & ~EX_br_taken;

  // Redirect takes priority: the stalled instruction is on the wrong path anyway.
  always_comb begin
    o_pc_stall = 1'b0;
    o_IF_stall = 1'b0;
    o_ID_flush = 1'b0;
    EX_flush   = 1'b0;
    if (EX_br_taken) begin
      o_ID_flush = 1'b1;
      EX_flush   = 1'b1;
    end else if (hazard) begin
      o_pc_stall = 1'b1;
      o_IF_stall = 1'b1;
      EX_flush   = 1'b1;
    end
  end

  always_comb begin
    trk_d[TrkEx] = '0;
    if (issue) begin
      trk_d[TrkEx].valid = ID_rd_wren && (ID_rd_addr != RegX0);
      trk_d[TrkEx].rd    = ID_rd_addr;
    end
    for (int i = 1; i < TrackDepth; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < TrackDepth; i++) begin
        trk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < TrackDepth; i++) begin
        trk_q[i] <= trk_d[i];
      end
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst),
    .inc_i  (stall_inc),
    .cnt_o  (o_stall_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst),
    .inc_i  (EX_br_taken),
    .cnt_o  (o_flush_cnt)
  );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Bench for id_hazard_ctrl: three configurations driven in lockstep and
// compared against a history-based reference model.
module tb_id_hazard_ctrl;

  logic       i_clk;
  logic       i_rst;
  logic       ID_insn_vld;
  logic [4:0] ID_rs1_addr, ID_rs2_addr, ID_rd_addr;
  logic       ID_rs1_used, ID_rs2_used, ID_rd_wren, EX_br_taken;

  logic        a_pc, a_if, a_idf, a_exf;
  logic [15:0] a_sc, a_fc;
  logic        b_pc, b_if, b_idf, b_exf;
  logic [15:0] b_sc, b_fc;
  logic        c_pc, c_if, c_idf, c_exf;
  logic [3:0]  c_sc, c_fc;

  int checks;
  int failures;

  // Reference model: rd of the writer issued k cycles ago sits at index k
  // (0 when nothing writable issued that cycle).
  int hA[$];
  int hB[$];
  int sA, fA, sB, fB, sC, fC;

  id_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16)) u_dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .ID_insn_vld(ID_insn_vld),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd_addr(ID_rd_addr), .ID_rd_wren(ID_rd_wren), .EX_br_taken(EX_br_taken),
    .o_pc_stall(a_pc), .o_IF_stall(a_if), .o_ID_flush(a_idf), .EX_flush(a_exf),
    .o_stall_cnt(a_sc), .o_flush_cnt(a_fc)
  );

  id_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(16)) u_dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .ID_insn_vld(ID_insn_vld),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd_addr(ID_rd_addr), .ID_rd_wren(ID_rd_wren), .EX_br_taken(EX_br_taken),
    .o_pc_stall(b_pc), .o_IF_stall(b_if), .o_ID_flush(b_idf), .EX_flush(b_exf),
    .o_stall_cnt(b_sc), .o_flush_cnt(b_fc)
  );

  id_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(4)) u_dut_c (
    .i_clk(i_clk), .i_rst(i_rst), .ID_insn_vld(ID_insn_vld),
    .ID_rs1_addr(ID_rs1_addr), .ID_rs2_addr(ID_rs2_addr),
    .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
    .ID_rd_addr(ID_rd_addr), .ID_rd_wren(ID_rd_wren), .EX_br_taken(EX_br_taken),
    .o_pc_stall(c_pc), .o_IF_stall(c_if), .o_ID_flush(c_idf), .EX_flush(c_exf),
    .o_stall_cnt(c_sc), .o_flush_cnt(c_fc)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    logic [4:0] rd;
    logic       wren;
    logic       br;
    logic [3:0] exp_ctl;  // {pc_stall, IF_stall, ID_flush, EX_flush}
    int         exp_stall;
    int         exp_flush;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(logic vld, int rs1, logic rs1u, int rs2, logic rs2u, int rd,
                              logic wren, logic br, logic [3:0] ctl, int st, int fl);
    vec_t v;
    v.vld = vld; v.rs1 = 5'(rs1); v.rs1u = rs1u; v.rs2 = 5'(rs2); v.rs2u = rs2u;
    v.rd = 5'(rd); v.wren = wren; v.br = br;
    v.exp_ctl = ctl; v.exp_stall = st; v.exp_flush = fl;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input int rs1, input logic rs1u, input int rs2,
                       input logic rs2u, input int rd, input logic wren, input logic br);
    ID_insn_vld = vld; ID_rs1_addr = 5'(rs1); ID_rs1_used = rs1u;
    ID_rs2_addr = 5'(rs2); ID_rs2_used = rs2u;
    ID_rd_addr = 5'(rd); ID_rd_wren = wren; EX_br_taken = br;
  endtask

  // Does any writer issued within the last win cycles produce a register the ID insn reads?
  function automatic bit mhaz(input int q[$], input int win);
    if (!ID_insn_vld) return 1'b0;
    for (int k = 0; k < win && k < q.size(); k++) begin
      if (q[k] != 0) begin
        if (ID_rs1_used && ID_rs1_addr != 0 && int'(ID_rs1_addr) == q[k]) return 1'b1;
        if (ID_rs2_used && ID_rs2_addr != 0 && int'(ID_rs2_addr) == q[k]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic logic [3:0] ctl_of(input bit h);
    if (EX_br_taken) return 4'b0011;
    if (h) return 4'b1101;
    return 4'b0000;
  endfunction

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_clear();
    hA.delete(); hB.delete();
    sA = 0; fA = 0; sB = 0; fB = 0; sC = 0; fC = 0;
  endtask

  task automatic push_hist(inout int q[$], input bit h);
    int w;
    w = (ID_insn_vld && !h && !EX_br_taken && ID_rd_wren) ? int'(ID_rd_addr) : 0;
    q.push_front(w);
    if (q.size() > 3) void'(q.pop_back());
  endtask

  bit ha_s, hb_s;

  task automatic step_pre();
    #2;
    ha_s = mhaz(hA, 2);
    hb_s = mhaz(hB, 3);
    chk("ctl_a", int'({a_pc, a_if, a_idf, a_exf}), int'(ctl_of(ha_s)));
    chk("ctl_b", int'({b_pc, b_if, b_idf, b_exf}), int'(ctl_of(hb_s)));
    chk("ctl_c", int'({c_pc, c_if, c_idf, c_exf}), int'(ctl_of(ha_s)));
  endtask

  task automatic step_post();
    @(posedge i_clk);
    if (ha_s && !EX_br_taken) begin sA = sat(sA + 1, 65535); sC = sat(sC + 1, 15); end
    if (hb_s && !EX_br_taken) sB = sat(sB + 1, 65535);
    if (EX_br_taken) begin
      fA = sat(fA + 1, 65535); fB = sat(fB + 1, 65535); fC = sat(fC + 1, 15);
    end
    push_hist(hA, ha_s);
    push_hist(hB, hb_s);
    #1;
    chk("stall_a", int'(a_sc), sA); chk("flush_a", int'(a_fc), fA);
    chk("stall_b", int'(b_sc), sB); chk("flush_b", int'(b_fc), fB);
    chk("stall_c", int'(c_sc), sC); chk("flush_c", int'(c_fc), fC);
  endtask

  task automatic do_reset();
    i_rst = 1'b0;
    model_clear();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    model_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    i_rst = 1'b0;
    #3;
    chk("rst_ctl", int'({a_pc, a_if, a_idf, a_exf}), 0);
    chk("rst_stall", int'(a_sc), 0);
    chk("rst_flush", int'(a_fc), 0);
    do_reset();

    tbl[0]  = mk(1, 1, 1, 0, 0, 5, 1, 0, 4'b0000, 0, 0);
    tbl[1]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 4'b1101, 1, 0);
    tbl[2]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 4'b1101, 2, 0);
    tbl[3]  = mk(1, 5, 1, 0, 0, 0, 0, 0, 4'b0000, 2, 0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 4'b0000, 2, 0);
    tbl[5]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 2, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 4'b0000, 2, 0);
    tbl[7]  = mk(1, 7, 0, 7, 1, 0, 0, 0, 4'b1101, 3, 0);
    tbl[8]  = mk(1, 7, 0, 7, 1, 0, 0, 1, 4'b0011, 3, 1);
    tbl[9]  = mk(1, 7, 1, 0, 0, 10, 1, 1, 4'b0011, 3, 2);
    tbl[10] = mk(1, 10, 1, 0, 0, 0, 0, 0, 4'b0000, 3, 2);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 3, 2);
    tbl[12] = mk(1, 0, 0, 0, 0, 3, 1, 0, 4'b0000, 3, 2);
    tbl[13] = mk(0, 3, 1, 0, 0, 0, 0, 0, 4'b0000, 3, 2);
    tbl[14] = mk(1, 3, 1, 0, 0, 0, 0, 0, 4'b1101, 4, 2);
    tbl[15] = mk(1, 3, 1, 0, 0, 0, 0, 0, 4'b0000, 4, 2);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].vld, int'(tbl[i].rs1), tbl[i].rs1u, int'(tbl[i].rs2), tbl[i].rs2u,
            int'(tbl[i].rd), tbl[i].wren, tbl[i].br);
      step_pre();
      chk($sformatf("tbl%0d_ctl", i), int'({a_pc, a_if, a_idf, a_exf}), int'(tbl[i].exp_ctl));
      step_post();
      chk($sformatf("tbl%0d_stall", i), int'(a_sc), tbl[i].exp_stall);
      chk($sformatf("tbl%0d_flush", i), int'(a_fc), tbl[i].exp_flush);
      if (i == 4) chk("nobypass_stall3", int'(b_sc), 3);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 8) != 0, $urandom_range(0, 7), $urandom % 2, $urandom_range(0, 7),
            $urandom % 2, $urandom_range(0, 7), ($urandom % 10) < 7, ($urandom % 10) == 0);
      step_pre();
      step_post();
    end

    // Self-dependent instruction held in ID keeps re-stalling; 4-bit counter must pin at 15
    do_reset();
    drive(1, 5, 1, 0, 0, 5, 1, 0);
    for (int n = 0; n < 40; n++) begin
      step_pre();
      step_post();
    end
    chk("sat_c_stall", int'(c_sc), 15);

    // Reset asserted between edges in the middle of a stall
    do_reset();
    drive(1, 0, 0, 0, 0, 5, 1, 0);
    step_pre();
    step_post();
    drive(1, 5, 1, 0, 0, 0, 0, 0);
    step_pre();
    step_post();
    step_pre();
    chk("midstall_pc_before", int'(a_pc), 1);
    chk("midstall_cnt_before", int'(a_sc), 1);
    i_rst = 1'b0;
    model_clear();
    #1;
    chk("midrst_pc", int'(a_pc), 0);
    chk("midrst_if", int'(a_if), 0);
    chk("midrst_exf", int'(a_exf), 0);
    chk("midrst_stall_a", int'(a_sc), 0);
    chk("midrst_stall_b", int'(b_sc), 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step_pre();
      step_post();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_hazard_ctrl.md
ID_HAZARD_CTRL -- requirements
Module: id_hazard_ctrl

Interface
REQ-001 Parameter WB_BYPASS, default 1, meaning register file returns same-cycle WB write data on read (1) or not (0).
REQ-002 Parameter CNT_W, default 16, meaning width of the performance counters.
REQ-003 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 ID_insn_vld  input  1  instruction in ID is valid.
REQ-006 ID_rs1_addr, ID_rs2_addr  input  5 each  source register addresses of the ID instruction.
REQ-007 ID_rs1_used, ID_rs2_used  input  1 each  ID instruction actually reads rs1/rs2.
REQ-008 ID_rd_addr  input  5  destination register of the ID instruction.
REQ-009 ID_rd_wren  input  1  ID instruction writes rd.
REQ-010 EX_br_taken  input  1  EX stage redirects the PC this cycle (taken branch or jump).
REQ-011 o_pc_stall  output  1  hold PC.
REQ-012 o_IF_stall  output  1  hold IF/ID buffer contents.
REQ-013 o_ID_flush  output  1  clear IF/ID buffer to a bubble.
REQ-014 EX_flush  output  1  load a bubble into the ID/EX buffer.
REQ-015 o_stall_cnt, o_flush_cnt  output  CNT_W each  saturating counts of hazard-stall cycles and redirect cycles.

Function
REQ-016 Block SHALL keep an in-flight tracker of three entries (EX, MEM, WB), each {valid, rd}.
REQ-017 Each cycle tracker SHALL shift EX->MEM->WB; WB entry is discarded.
REQ-018 New EX entry SHALL be {ID_insn_vld & ID_rd_wren & (ID_rd_addr!=0), ID_rd_addr} when the ID instruction issues, else {0, 0}.
REQ-019 Issue SHALL mean ID_insn_vld & ~hazard & ~EX_br_taken.
REQ-020 Source match SHALL mean rsN_used & rsN_addr!=0 & entry.valid & entry.rd==rsN_addr, for N in {1,2}.
REQ-021 hazard SHALL be ID_insn_vld & (match against EX or MEM entry, or WB entry when WB_BYPASS==0).
REQ-022 hazard & ~EX_br_taken SHALL give o_pc_stall=1, o_IF_stall=1, o_ID_flush=0, EX_flush=1.
REQ-023 EX_br_taken SHALL give o_pc_stall=0, o_IF_stall=0, o_ID_flush=1, EX_flush=1, regardless of hazard.
REQ-024 Neither condition SHALL give all four control outputs 0.
REQ-025 Control outputs SHALL be combinational from current inputs and tracker state (zero-cycle latency).
REQ-026 o_stall_cnt SHALL increment by 1 on each cycle of REQ-022; o_flush_cnt SHALL increment on each cycle with EX_br_taken=1.
REQ-027 Counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 Writes to x0 SHALL never create a hazard; reads of x0 SHALL never stall.
REQ-029 A load-use or ALU-use dependency SHALL stall until the producer leaves the last checked entry, i.e. at most 2 cycles (WB_BYPASS=1) or 3 cycles (WB_BYPASS=0).

Reset
REQ-030 While i_rst=0 all tracker entries SHALL be {0,0} and both counters 0, taking effect asynchronously.
REQ-031 Control outputs SHALL follow REQ-022..024 during reset using the cleared tracker (no spurious stall).
REQ-032 Reset asserted mid-stall SHALL clear the tracker so the stall ends in the same cycle.
REQ-033 First rising edge after i_rst deasserts SHALL behave as a normal cycle.

Structure
REQ-034 Tracker entry struct {valid, rd[4:0]}, tracker depth 3 and x0 address constant SHALL live in shared package rv_pipe_pkg.
REQ-035 One sub-module sat_counter (parameterised width, increment enable, async active-low reset) SHALL be instantiated twice for the counters.
REQ-036 Hazard compare and control-output logic SHALL stay in id_hazard_ctrl.

Verification
REQ-037 addi x5 issues, next cycle ID reads x5 (rs1_used=1), WB_BYPASS=1 -> o_pc_stall/o_IF_stall/EX_flush=1 for exactly 2 cycles, o_stall_cnt=2.
REQ-038 Same sequence with WB_BYPASS=0 -> stall for exactly 3 cycles, o_stall_cnt=3.
REQ-039 Producer writes x0, consumer reads x0 -> no stall, counters remain 0.
REQ-040 Hazard present and EX_br_taken=1 same cycle -> o_ID_flush=1, EX_flush=1, o_pc_stall=0; next cycle tracker EX entry invalid; o_flush_cnt=1, o_stall_cnt=0.
REQ-041 Drive hazard continuously with CNT_W=4 -> o_stall_cnt holds at 15.
REQ-042 Assert i_rst=0 mid-stall between clock edges -> stall outputs drop immediately, counters read 0.
